// File: rtl/count_step_checker.sv
// count_step_checker
// Watches an up/down counter bus. Each valid sample is checked against a
// prediction built from the previous sample: previous count plus or minus one,
// with the step taken from the previous sample's direction.
// Mismatches are flagged, counted and latched. A small FSM tracks whether the
// counter is currently trusted:
//   IDLE  - the next valid sample only primes the predictor
//   TRACK - samples have been matching
//   FAULT - a mismatch was seen; two matches in a row return to TRACK
// Optional feature: define CNT_CHK_WRAP_CNT_EN to add the wrap_up_cnt and
// wrap_dn_cnt ports. These count matched wraps in each direction.
module count_step_checker #(
  parameter int WIDTH = 3,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             updown,
  input  logic [WIDTH-1:0] count,
  input  logic             err_clr,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt,
  output logic             dir_change,
  output logic [1:0]       state
`ifdef CNT_CHK_WRAP_CNT_EN
  ,
  output logic [ERR_W-1:0] wrap_up_cnt,
  output logic [ERR_W-1:0] wrap_dn_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] prev_count_reg;
  logic             prev_dir_reg;
  logic             match_run_reg;   // one match already seen while in FAULT
  logic             err_pulse_reg;
  logic             dir_change_reg;
  logic             err_sticky_reg;
  logic [ERR_W-1:0] err_cnt_reg;

  logic [WIDTH-1:0] prediction;
  logic             checked;
  logic             mismatch;

  // Expected next value of the monitored counter, wrapping modulo 2^WIDTH.
  always_comb begin
    prediction = prev_dir_reg ? (prev_count_reg + WIDTH'(1))
                              : (prev_count_reg - WIDTH'(1));
    checked    = valid && (state_reg != IDLE);
    mismatch   = checked && (count != prediction);
  end

  // FSM, sample registers and the one-cycle flags. A mismatching sample is
  // still loaded, so the predictor resyncs to the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      prev_count_reg <= '0;
      prev_dir_reg   <= 1'b0;
      match_run_reg  <= 1'b0;
      err_pulse_reg  <= 1'b0;
      dir_change_reg <= 1'b0;
    end else begin
      if (valid) begin
        prev_count_reg <= count;
        prev_dir_reg   <= updown;
      end
      err_pulse_reg  <= mismatch;
      dir_change_reg <= checked && (updown != prev_dir_reg);
      case (state_reg)
        IDLE: begin
          match_run_reg <= 1'b0;
          if (valid) state_reg <= TRACK;
        end
        TRACK: begin
          match_run_reg <= 1'b0;
          if (!valid)        state_reg <= IDLE;
          else if (mismatch) state_reg <= FAULT;
        end
        FAULT: begin
          if (!valid) begin
            state_reg     <= IDLE;
            match_run_reg <= 1'b0;
          end else if (mismatch) begin
            match_run_reg <= 1'b0;
          end else if (match_run_reg) begin
            state_reg     <= TRACK;
            match_run_reg <= 1'b0;
          end else begin
            match_run_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          match_run_reg <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag and saturating error count. A clear that coincides with a
  // mismatch leaves exactly that one mismatch recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_reg <= 1'b0;
      err_cnt_reg    <= '0;
    end else if (err_clr) begin
      err_sticky_reg <= mismatch;
      err_cnt_reg    <= mismatch ? ERR_W'(1) : '0;
    end else if (mismatch) begin
      err_sticky_reg <= 1'b1;
      if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + ERR_W'(1);
    end
  end

`ifdef CNT_CHK_WRAP_CNT_EN
  logic [ERR_W-1:0] wrap_up_cnt_reg;
  logic [ERR_W-1:0] wrap_dn_cnt_reg;
  logic             wrap_up_hit;
  logic             wrap_dn_hit;

  // A wrap is recognised only on a sample that matched its prediction.
  always_comb begin
    wrap_up_hit = checked && !mismatch && prev_dir_reg &&
                  (prev_count_reg == '1) && (count == '0);
    wrap_dn_hit = checked && !mismatch && !prev_dir_reg &&
                  (prev_count_reg == '0) && (count == '1);
  end

  // Saturating wrap counters; err_clr deliberately leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_up_cnt_reg <= '0;
      wrap_dn_cnt_reg <= '0;
    end else begin
      if (wrap_up_hit && (wrap_up_cnt_reg != '1))
        wrap_up_cnt_reg <= wrap_up_cnt_reg + ERR_W'(1);
      if (wrap_dn_hit && (wrap_dn_cnt_reg != '1))
        wrap_dn_cnt_reg <= wrap_dn_cnt_reg + ERR_W'(1);
    end
  end

  assign wrap_up_cnt = wrap_up_cnt_reg;
  assign wrap_dn_cnt = wrap_dn_cnt_reg;
`endif

  assign err_pulse  = err_pulse_reg;
  assign dir_change = dir_change_reg;
  assign err_sticky = err_sticky_reg;
  assign err_cnt    = err_cnt_reg;
  assign state      = state_reg;

endmodule

// File: doc/count_step_checker.md
COUNT_STEP_CHECKER -- requirements
Module: count_step_checker

Interface
REQ-001 Parameter WIDTH, default 3: width of the monitored count bus.
REQ-002 Parameter ERR_W, default 8: width of all event counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 valid  input  1  count/updown are meaningful this cycle.
REQ-006 updown  input  1  direction applied by upstream counter at this edge: 1=up, 0=down.
REQ-007 count  input  WIDTH  counter output being monitored.
REQ-008 err_clr  input  1  synchronous clear of err_sticky and err_cnt.
REQ-009 err_pulse  output  1  one-cycle flag: last sample mismatched prediction.
REQ-010 err_sticky  output  1  set on any mismatch, held until err_clr or rst.
REQ-011 err_cnt  output  ERR_W  saturating mismatch count.
REQ-012 dir_change  output  1  one-cycle flag: direction differs from previous sample.
REQ-013 state  output  2  FSM state: 0=IDLE, 1=TRACK, 2=FAULT.
REQ-014 wrap_up_cnt, wrap_dn_cnt  output  ERR_W each  saturating wrap counts (present only with macro, see Configuration).

Function
REQ-015 Sample registers prev_count (WIDTH) and prev_dir (1) SHALL load count/updown on every valid cycle.
REQ-016 Prediction SHALL be prev_count+1 when prev_dir=1, prev_count-1 when prev_dir=0, modulo 2^WIDTH.
REQ-017 IDLE: valid=1 -> load sample, go TRACK, no check, no flags.
REQ-018 TRACK: valid=1 and count==prediction -> stay TRACK; mismatch -> go FAULT.
REQ-019 FAULT: checking continues identically; two consecutive matching samples -> TRACK; any mismatch resets the match run.
REQ-020 TRACK or FAULT with valid=0 -> IDLE next cycle; counters and err_sticky retained.
REQ-021 On mismatch, new sample SHALL still be loaded (resync); next prediction uses it.
REQ-022 err_pulse, dir_change SHALL assert exactly one cycle after the sampling edge (registered, latency 1), and only for checked samples (TRACK/FAULT, valid=1).
REQ-023 dir_change SHALL assert when updown != prev_dir; independent of match result.
REQ-024 err_cnt SHALL increment by 1 per mismatch and hold at 2^ERR_W-1.
REQ-025 err_clr with simultaneous mismatch: err_cnt=1, err_sticky=1.
REQ-026 err_clr SHALL NOT affect state, sample registers or wrap counters.

Reset
REQ-027 rst=1 SHALL dominate all inputs including err_clr and valid.
REQ-028 Values after reset: state=IDLE, prev_count=0, prev_dir=0, err_pulse=0, err_sticky=0, err_cnt=0, dir_change=0, wrap counters=0.
REQ-029 rst asserted mid-FAULT or mid-TRACK SHALL discard the pending sample; first valid after release is an IDLE prime.

Configuration
REQ-030 Macro CNT_CHK_WRAP_CNT_EN defined: wrap_up_cnt increments on matching sample with prev_count=2^WIDTH-1, prev_dir=1, count=0; wrap_dn_cnt on matching sample with prev_count=0, prev_dir=0, count=2^WIDTH-1; both saturate.
REQ-031 Macro undefined: wrap_up_cnt/wrap_dn_cnt ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 rst=1 two cycles, then valid=1, updown=1, count 0,1,2..7,0,1 -> state IDLE->TRACK, err_pulse never 1, wrap_up_cnt=1 (macro on).
REQ-033 TRACK, up, count 3,4,6,7 -> err_pulse=1 one cycle after 6 sampled, err_cnt=1, state FAULT, then TRACK after 7 and next match 0.
REQ-034 count 2,1,0 with updown=0, then updown=1 at count 0, count 1 -> wrap_dn_cnt=0, dir_change=1 once, err_cnt=0.
REQ-035 err_cnt preloaded to 255 via 255 mismatches, one more mismatch -> err_cnt stays 255; err_clr with mismatch same cycle -> err_cnt=1.
REQ-036 valid=0 one cycle in TRACK, then count jumps 2->5 -> state IDLE then TRACK, no error.
REQ-037 rst=1 while state=FAULT and err_clr=1 -> all outputs at reset values next cycle, state IDLE.
